// File: rtl/ext_pipe.sv
// Registered immediate extender with a 2-entry result FIFO and valid/ready handshake on both sides.
// Reserved extension modes yield a zero result tagged bad_op and latch err_sticky.
module ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int SH_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  imm,
  input  logic [2:0]        EOp,
  input  logic [SH_W-1:0]   shamt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext,
  output logic              bad_op,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  done_cnt
);

  logic [DATA_W-1:0] mem_r [2];
  logic              bad_mem_r [2];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        count_r;
  logic              err_r;
  logic [CNT_W-1:0]  done_r;

  logic [DATA_W-1:0] sx_s;
  logic [DATA_W-1:0] zx_s;
  logic [DATA_W-1:0] res_s;
  logic              res_bad_s;
  logic              push_s;
  logic              pop_s;

  assign sx_s = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign zx_s = {{(DATA_W-IMM_W){1'b0}}, imm};

  // Extension result computed at the input; only the stored value is ever presented.
  always_comb begin
    res_s     = {DATA_W{1'b0}};
    res_bad_s = 1'b0;
    case (EOp)
      3'b000:  res_s = sx_s;
      3'b001:  res_s = zx_s;
      3'b010:  res_s = {imm, {(DATA_W-IMM_W){1'b0}}};
      3'b011:  res_s = sx_s << 2;
      3'b100:  res_s = sx_s << shamt;
      3'b101:  res_s = zx_s << shamt;
      default: begin
        res_s     = {DATA_W{1'b0}};
        res_bad_s = 1'b1;
      end
    endcase
  end

  // Handshake depends on stored occupancy only, so no in-to-out combinational path exists.
  assign in_ready   = (count_r != 2'd2);
  assign out_valid  = (count_r != 2'd0);
  assign push_s     = in_valid & in_ready;
  assign pop_s      = out_valid & out_ready;
  assign ext        = out_valid ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};
  assign bad_op     = out_valid ? bad_mem_r[rd_ptr_r] : 1'b0;
  assign err_sticky = err_r;
  assign done_cnt   = done_r;

  // FIFO storage, pointers, occupancy, sticky error and transfer counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_r[0]     <= {DATA_W{1'b0}};
      mem_r[1]     <= {DATA_W{1'b0}};
      bad_mem_r[0] <= 1'b0;
      bad_mem_r[1] <= 1'b0;
      wr_ptr_r     <= 1'b0;
      rd_ptr_r     <= 1'b0;
      count_r      <= 2'd0;
      err_r        <= 1'b0;
      done_r       <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r]     <= res_s;
        bad_mem_r[wr_ptr_r] <= res_bad_s;
        wr_ptr_r            <= ~wr_ptr_r;
        if (res_bad_s) begin
          err_r <= 1'b1;
        end
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
        done_r   <= done_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed self-checking bench for ext_pipe; uses CNT_W = 4 so the transfer counter wrap is reachable.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] imm;
  logic [2:0]  EOp;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ext;
  logic        bad_op;
  logic        err_sticky;
  logic [3:0]  done_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] sweep_exp [8];

  ext_pipe #(.IMM_W(16), .DATA_W(32), .SH_W(5), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .EOp(EOp), .shamt(shamt), .out_valid(out_valid),
    .out_ready(out_ready), .ext(ext), .bad_op(bad_op),
    .err_sticky(err_sticky), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sweep_exp[0] = 32'hFFFF8001; sweep_exp[1] = 32'h00008001;
    sweep_exp[2] = 32'h80010000; sweep_exp[3] = 32'hFFFE0004;
    sweep_exp[4] = 32'hFFF80010; sweep_exp[5] = 32'h00080010;
    sweep_exp[6] = 32'h00000000; sweep_exp[7] = 32'h00000000;

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    imm = 16'h0000; EOp = 3'b000; shamt = 5'd0;
    tick(); tick();
    reset = 1'b1;
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_ext", ext, 32'd0);
    check_val("rst_bad_op", 32'(bad_op), 32'd0);
    check_val("rst_err", 32'(err_sticky), 32'd0);
    check_val("rst_done", 32'(done_cnt), 32'd0);

    // Mode sweep: each new push overlaps the pop of the previous entry
    out_ready = 1'b1; imm = 16'h8001; shamt = 5'd4; in_valid = 1'b1;
    for (int m = 0; m < 8; m++) begin
      EOp = 3'(m);
      tick();
      check_val($sformatf("sweep_ext_%0d", m), ext, sweep_exp[m]);
      check_val($sformatf("sweep_bad_%0d", m), 32'(bad_op), (m >= 6) ? 32'd1 : 32'd0);
      check_val($sformatf("sweep_err_%0d", m), 32'(err_sticky), (m >= 6) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    tick();
    check_val("sweep_empty_valid", 32'(out_valid), 32'd0);
    check_val("sweep_empty_ext", ext, 32'd0);
    check_val("sweep_done", 32'(done_cnt), 32'd8);

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1; EOp = 3'b001; imm = 16'h0001;
    tick();
    check_val("bp_ready_1", 32'(in_ready), 32'd1);
    imm = 16'h0002;
    tick();
    check_val("bp_ready_2", 32'(in_ready), 32'd0);
    imm = 16'h0003;
    tick();
    check_val("bp_held_ready", 32'(in_ready), 32'd0);
    check_val("bp_head_1", ext, 32'h00000001);
    out_ready = 1'b1;
    tick();
    check_val("bp_head_2", ext, 32'h00000002);
    check_val("bp_ready_after_pop", 32'(in_ready), 32'd1);
    tick();
    check_val("bp_head_3", ext, 32'h00000003);
    in_valid = 1'b0;
    tick();
    check_val("bp_done", 32'(done_cnt), 32'd11);
    check_val("bp_empty", 32'(out_valid), 32'd0);

    // Simultaneous push/pop at count 1
    in_valid = 1'b1; EOp = 3'b001; imm = 16'h0100;
    tick();
    for (int k = 1; k <= 10; k++) begin
      imm = 16'h0100 + 16'(k);
      tick();
      check_val($sformatf("pp_valid_%0d", k), 32'(out_valid), 32'd1);
      check_val($sformatf("pp_ext_%0d", k), ext, 32'h00000100 + 32'(k));
      check_val($sformatf("pp_ready_%0d", k), 32'(in_ready), 32'd1);
    end
    check_val("pp_done", 32'(done_cnt), 32'd5);
    in_valid = 1'b0;
    tick();
    check_val("pp_done_final", 32'(done_cnt), 32'd6);

    // Variable shift edge cases
    in_valid = 1'b1; EOp = 3'b100; imm = 16'hFFFF; shamt = 5'd31;
    tick();
    check_val("sh_sx31", ext, 32'h80000000);
    EOp = 3'b101; imm = 16'h0003;
    tick();
    check_val("sh_zx31", ext, 32'h80000000);
    in_valid = 1'b0;
    tick();
    check_val("sh_done", 32'(done_cnt), 32'd8);

    // Reset mid-stream with the FIFO full
    out_ready = 1'b0; in_valid = 1'b1; EOp = 3'b001; shamt = 5'd0; imm = 16'h0005;
    tick();
    imm = 16'h0006;
    tick();
    check_val("mr_full", 32'(in_ready), 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    tick();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    check_val("mr_out_valid", 32'(out_valid), 32'd0);
    check_val("mr_in_ready", 32'(in_ready), 32'd1);
    check_val("mr_ext", ext, 32'd0);
    check_val("mr_err", 32'(err_sticky), 32'd0);
    check_val("mr_done", 32'(done_cnt), 32'd0);
    in_valid = 1'b1; EOp = 3'b000; imm = 16'h8001;
    tick();
    in_valid = 1'b0;
    check_val("mr_first_ext", ext, 32'hFFFF8001);
    check_val("mr_first_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check_val("mr_first_done", 32'(done_cnt), 32'd1);

    // Counter wrap: 17 pops from zero
    reset = 1'b0;
    tick();
    reset = 1'b1;
    in_valid = 1'b1; EOp = 3'b001; imm = 16'h0000;
    for (int k = 0; k < 17; k++) begin
      imm = 16'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check_val("wrap_done", 32'(done_cnt), 32'd1);
    tick();
    check_val("idle_pop_ignored", 32'(done_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
